// File: rtl/dual_b_coef_ctrl_if.sv
// Coefficient handshake, configuration and dual-B register stage controls.
// master = coefficient source side, slave = dual_b_coef_ctrl.
interface dual_b_coef_ctrl_if;
    logic        coef_valid;
    logic [17:0] coef_data;
    logic        coef_ready;
    logic        swap_req;
    logic        cfg_cascade;
    logic        cfg_preview;
    logic [17:0] B;
    logic        B_INPUT;
    logic        CEB1;
    logic        CEB2;
    logic [1:0]  BREG;
    logic        IN_MODE;
    logic        staged;
    logic        commit_done;

    modport master (
        output coef_valid, coef_data, swap_req, cfg_cascade, cfg_preview,
        input  coef_ready, B, B_INPUT, CEB1, CEB2, BREG, IN_MODE, staged, commit_done
    );

    modport slave (
        input  coef_valid, coef_data, swap_req, cfg_cascade, cfg_preview,
        output coef_ready, B, B_INPUT, CEB1, CEB2, BREG, IN_MODE, staged, commit_done
    );
endinterface

// File: rtl/dual_b_coef_ctrl.sv
// Coefficient double-buffer sequencer for a dual-B register stage (B1 staged, B2 committed).
// Latency: CEB1 one cycle after handshake; commit_done COMMIT_LAT cycles after the B2 update edge.
// Backpressure: coef_ready low from acceptance until one cycle after commit_done.
// Optional: DUAL_B_COEF_CTRL_COMMIT_CNT_EN adds o_commit_cnt.
module dual_b_coef_ctrl #(
    parameter int unsigned COMMIT_LAT  = 1,
    parameter int unsigned AUTO_PERIOD = 0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    dual_b_coef_ctrl_if.slave  bus
`ifdef DUAL_B_COEF_CTRL_COMMIT_CNT_EN
    ,
    output logic [15:0]        o_commit_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STAGED,
        S_COMMIT,
        S_WAIT
    } state_t;

    state_t      r_state;
    state_t      w_nxt_state;
    logic [17:0] r_b;
    logic        r_ceb1;
    logic        r_ceb2;
    logic        r_b_input;
    logic [1:0]  r_breg;
    logic        r_in_mode;
    logic        r_staged;
    logic        r_commit_done;
    logic        r_coef_ready;
    logic [3:0]  r_lat_cnt;

    logic        w_auto_tick;
    logic        w_load_b;
    logic        w_nxt_ceb1;
    logic        w_nxt_ceb2;
    logic        w_nxt_staged;
    logic        w_nxt_done;
    logic        w_nxt_ready;
    logic [3:0]  w_nxt_lat;

    generate
        if (AUTO_PERIOD != 0) begin : g_auto
            localparam int PW = $clog2(AUTO_PERIOD);
            logic [PW-1:0] r_period_cnt;

            always_ff @(posedge i_clk) begin
                if (!i_rst) begin
                    r_period_cnt <= '0;
                end else if (r_period_cnt == PW'(AUTO_PERIOD - 1)) begin
                    r_period_cnt <= '0;
                end else begin
                    r_period_cnt <= r_period_cnt + PW'(1);
                end
            end

            assign w_auto_tick = (r_period_cnt == PW'(AUTO_PERIOD - 1));
        end else begin : g_no_auto
            assign w_auto_tick = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    always_comb begin
        w_nxt_state  = r_state;
        w_load_b     = 1'b0;
        w_nxt_ceb1   = 1'b0;
        w_nxt_ceb2   = 1'b0;
        w_nxt_staged = r_staged;
        w_nxt_done   = 1'b0;
        w_nxt_lat    = r_lat_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.coef_valid && r_coef_ready) begin
                    w_load_b    = 1'b1;
                    w_nxt_ceb1  = 1'b1;
                    w_nxt_state = S_LOAD;
                end
            end
            S_LOAD: begin
                w_nxt_staged = 1'b1;
                w_nxt_state  = S_STAGED;
            end
            S_STAGED: begin
                // A swap request coinciding with an auto tick is still one commit.
                if (bus.swap_req || w_auto_tick) begin
                    w_nxt_ceb2  = 1'b1;
                    w_nxt_state = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_nxt_staged = 1'b0;
                w_nxt_lat    = '0;
                w_nxt_state  = S_WAIT;
            end
            S_WAIT: begin
                if (r_lat_cnt == 4'(COMMIT_LAT - 1)) begin
                    w_nxt_done  = 1'b1;
                    w_nxt_state = S_IDLE;
                end else begin
                    w_nxt_lat = r_lat_cnt + 4'd1;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
        // Ready stays low through the commit_done cycle.
        w_nxt_ready = (w_nxt_state == S_IDLE) && (r_state != S_WAIT);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_b           <= '0;
            r_ceb1        <= 1'b0;
            r_ceb2        <= 1'b0;
            r_b_input     <= 1'b1;
            r_breg        <= 2'b11;
            r_in_mode     <= 1'b0;
            r_staged      <= 1'b0;
            r_commit_done <= 1'b0;
            r_coef_ready  <= 1'b1;
            r_lat_cnt     <= '0;
        end else begin
            if (w_load_b) begin
                r_b <= bus.coef_data;
            end
            if (r_state == S_IDLE) begin
                r_b_input <= ~bus.cfg_cascade;
            end
            r_ceb1        <= w_nxt_ceb1;
            r_ceb2        <= w_nxt_ceb2;
            r_breg        <= 2'b11;
            r_in_mode     <= bus.cfg_preview;
            r_staged      <= w_nxt_staged;
            r_commit_done <= w_nxt_done;
            r_coef_ready  <= w_nxt_ready;
            r_lat_cnt     <= w_nxt_lat;
        end
    end

`ifdef DUAL_B_COEF_CTRL_COMMIT_CNT_EN
    logic [15:0] r_commit_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_commit_cnt <= '0;
        end else if (w_nxt_done) begin
            r_commit_cnt <= r_commit_cnt + 16'd1;
        end
    end

    assign o_commit_cnt = r_commit_cnt;
`endif

    assign bus.B           = r_b;
    assign bus.B_INPUT     = r_b_input;
    assign bus.CEB1        = r_ceb1;
    assign bus.CEB2        = r_ceb2;
    assign bus.BREG        = r_breg;
    assign bus.IN_MODE     = r_in_mode;
    assign bus.staged      = r_staged;
    assign bus.commit_done = r_commit_done;
    assign bus.coef_ready  = r_coef_ready;

endmodule

// File: tb/tb_dual_b_coef_ctrl.sv
// Bench for dual_b_coef_ctrl: two instances (LAT=1/no auto, LAT=3/period 8) under random traffic,
// checked every cycle against an event-timestamp model of the commit timeline.
module tb_dual_b_coef_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        drv_vld  [2];
    logic [17:0] drv_dat  [2];
    logic        drv_swap [2];
    logic        drv_casc;
    logic        drv_prev;

    dual_b_coef_ctrl_if bus0 ();
    dual_b_coef_ctrl_if bus1 ();

    assign bus0.coef_valid  = drv_vld[0];
    assign bus0.coef_data   = drv_dat[0];
    assign bus0.swap_req    = drv_swap[0];
    assign bus0.cfg_cascade = drv_casc;
    assign bus0.cfg_preview = drv_prev;
    assign bus1.coef_valid  = drv_vld[1];
    assign bus1.coef_data   = drv_dat[1];
    assign bus1.swap_req    = drv_swap[1];
    assign bus1.cfg_cascade = drv_casc;
    assign bus1.cfg_preview = drv_prev;

`ifdef DUAL_B_COEF_CTRL_COMMIT_CNT_EN
    logic [15:0] cnt0, cnt1;
`endif

    dual_b_coef_ctrl #(.COMMIT_LAT(1), .AUTO_PERIOD(0)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .bus(bus0)
`ifdef DUAL_B_COEF_CTRL_COMMIT_CNT_EN
        , .o_commit_cnt(cnt0)
`endif
    );

    dual_b_coef_ctrl #(.COMMIT_LAT(3), .AUTO_PERIOD(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .bus(bus1)
`ifdef DUAL_B_COEF_CTRL_COMMIT_CNT_EN
        , .o_commit_cnt(cnt1)
`endif
    );

    // Observed outputs: {ready, B, B_INPUT, CEB1, CEB2, BREG, IN_MODE, staged, commit_done}
    logic [26:0] obs [2];
    assign obs[0] = {bus0.coef_ready, bus0.B, bus0.B_INPUT, bus0.CEB1, bus0.CEB2,
                     bus0.BREG, bus0.IN_MODE, bus0.staged, bus0.commit_done};
    assign obs[1] = {bus1.coef_ready, bus1.B, bus1.B_INPUT, bus1.CEB1, bus1.CEB2,
                     bus1.BREG, bus1.IN_MODE, bus1.staged, bus1.commit_done};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: each transaction is described by the edge numbers of its accept, commit trigger
    // and done pulse; outputs follow from comparing the current edge number against them.
    int          lat [2] = '{1, 3};
    int          per [2] = '{0, 8};
    int          e_num;
    bit          m_open [2];
    int          m_acc  [2];
    int          m_com  [2];
    int          m_done [2];
    logic [17:0] m_b    [2];
    logic        m_bin  [2];
    logic        m_imode[2];
    logic [15:0] m_cnt  [2];
    bit          src_pend [2];

    task automatic model_reset();
        e_num = 0;
        for (int d = 0; d < 2; d++) begin
            m_open[d]  = 1'b0;
            m_acc[d]   = -10;
            m_com[d]   = -10;
            m_done[d]  = -10;
            m_b[d]     = '0;
            m_bin[d]   = 1'b1;
            m_imode[d] = 1'b0;
            m_cnt[d]   = '0;
        end
    endtask

    task automatic model_edge(input int d);
        bit ready_before, tick;
        ready_before = !m_open[d] && (m_done[d] != e_num - 1);
        tick = (per[d] != 0) && (e_num % per[d] == 0);
        if (!m_open[d]) m_bin[d] = ~drv_casc;
        m_imode[d] = drv_prev;
        if (ready_before && drv_vld[d]) begin
            m_open[d]   = 1'b1;
            m_acc[d]    = e_num;
            m_com[d]    = -1;
            m_b[d]      = drv_dat[d];
            src_pend[d] = 1'b0;
        end else if (m_open[d] && m_com[d] < 0 && e_num >= m_acc[d] + 2 && (drv_swap[d] || tick)) begin
            m_com[d] = e_num;
        end else if (m_open[d] && m_com[d] > 0 && e_num == m_com[d] + 1 + lat[d]) begin
            m_open[d] = 1'b0;
            m_done[d] = e_num;
            m_cnt[d]  = m_cnt[d] + 16'd1;
        end
    endtask

    task automatic check_dut(input int d);
        string p;
        logic  exp_staged;
        p = $sformatf("u%0d@e%0d", d, e_num);
        exp_staged = m_open[d] && (e_num >= m_acc[d] + 1) && (m_com[d] < 0 || e_num <= m_com[d]);
        check({p, ".coef_ready"},  32'(obs[d][26]),    32'(!m_open[d] && e_num != m_done[d]));
        check({p, ".B"},           32'(obs[d][25:8]),  32'(m_b[d]));
        check({p, ".B_INPUT"},     32'(obs[d][7]),     32'(m_bin[d]));
        check({p, ".CEB1"},        32'(obs[d][6]),     32'(e_num == m_acc[d]));
        check({p, ".CEB2"},        32'(obs[d][5]),     32'(m_com[d] > 0 && e_num == m_com[d]));
        check({p, ".BREG"},        32'(obs[d][4:3]),   32'd3);
        check({p, ".IN_MODE"},     32'(obs[d][2]),     32'(m_imode[d]));
        check({p, ".staged"},      32'(obs[d][1]),     32'(exp_staged));
        check({p, ".commit_done"}, 32'(obs[d][0]),     32'(e_num == m_done[d]));
`ifdef DUAL_B_COEF_CTRL_COMMIT_CNT_EN
        check({p, ".commit_cnt"},  32'(d == 0 ? cnt0 : cnt1), 32'(m_cnt[d]));
`endif
    endtask

    task automatic drive_next();
        for (int d = 0; d < 2; d++) begin
            if (!src_pend[d] && ($urandom % 3 != 0)) begin
                src_pend[d] = 1'b1;
                drv_dat[d]  = 18'($urandom);
            end
            drv_vld[d]  = src_pend[d];
            drv_swap[d] = ($urandom % 10 == 0);
        end
        if ($urandom % 16 == 0) drv_casc = ~drv_casc;
        if ($urandom % 4 == 0)  drv_prev = ~drv_prev;
        rst = ($urandom % 60 != 0);
    endtask

    initial begin
        rst      = 1'b0;
        drv_casc = 1'b0;
        drv_prev = 1'b0;
        for (int d = 0; d < 2; d++) begin
            src_pend[d] = 1'b1;
            drv_dat[d]  = 18'h1F00A;
            drv_vld[d]  = 1'b1;
            drv_swap[d] = 1'b0;
        end
        model_reset();
        repeat (3000) begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
            end else begin
                e_num++;
                for (int d = 0; d < 2; d++) model_edge(d);
            end
            @(negedge clk);
            for (int d = 0; d < 2; d++) check_dut(d);
            drive_next();
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dual_b_coef_ctrl.md
Name: dual_b_coef_ctrl

Overview:
- Sequencing controller for one dual-B input register stage (B1/B2 pipeline, CEB1/CEB2, BREG, IN_MODE, B_INPUT select).
- Implements coefficient double-buffering. A new 18-bit coefficient is accepted over a valid/ready handshake and staged into B1 with CEB1. It is committed into B2 with CEB2 on a swap request or an automatic period tick.
- The multiplier therefore sees a glitch-free coefficient change. Sits between the coefficient source (host/ROM sequencer) and the dual-B register stage.

Parameters:
- COMMIT_LAT, 1, cycles between the B2 update edge and the commit_done pulse (1..15).
- AUTO_PERIOD, 0, auto-commit period in clock cycles; 0 disables auto-commit (minimum nonzero value is 2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low. The dual-B stage is driven by the inverted copy of this reset.
- coef_valid  in  1  new coefficient offered.
- coef_data  in  18  signed coefficient.
- coef_ready  out  1  controller can accept a coefficient.
- swap_req  in  1  request to commit the staged coefficient (level, sampled each cycle).
- cfg_cascade  in  1  1 = source B from BCIN; 0 = direct B.
- cfg_preview  in  1  1 = multiplier uses B1 (staged) instead of B2.
- B  out  18  coefficient to the dual-B direct input.
- B_INPUT  out  1  select to the dual-B stage (1 = direct).
- CEB1  out  1  B1 clock enable.
- CEB2  out  1  B2 clock enable.
- BREG  out  2  register configuration to the dual-B stage.
- IN_MODE  out  1  multiplier operand select.
- staged  out  1  B1 holds an uncommitted coefficient.
- commit_done  out  1  one-cycle pulse after a commit.

Behaviour:
- All outputs are registered. Reset values (rst=0 at an edge):
  - B=0, CEB1=0, CEB2=0, B_INPUT=1, BREG=2'b11, IN_MODE=0, staged=0, commit_done=0.
  - Internal: state=IDLE, latency counter and period counter = 0.
- BREG is constant 2'b11 after reset. It is the only supported configuration, with both registers in use.
- IN_MODE = cfg_preview, registered.
- B_INPUT = ~cfg_cascade, latched only while in IDLE. A cfg_cascade change in any other state takes effect on return to IDLE.
- States: IDLE, LOAD, STAGED, COMMIT, WAIT.
- IDLE:
  - coef_ready=1.
  - On an edge with coef_valid & coef_ready: B<=coef_data, CEB1<=1, go to LOAD.
- LOAD:
  - CEB1=1 for exactly one cycle; B1 captures B at the end of this cycle.
  - Next: CEB1<=0, staged<=1, go to STAGED.
  - coef_ready=0.
- STAGED:
  - coef_ready=0.
  - Commit trigger = swap_req | auto_tick.
  - On trigger: CEB2<=1, go to COMMIT.
  - Further coef_valid is back-pressured and never lost.
- COMMIT:
  - CEB2=1 for exactly one cycle; B2 captures B1.
  - Next: CEB2<=0, staged<=0, latency counter<=0, go to WAIT.
- WAIT:
  - Counts COMMIT_LAT cycles.
  - On the last count, commit_done<=1 for one cycle and go to IDLE.
  - coef_ready=0 throughout WAIT.
- Auto-commit:
  - When AUTO_PERIOD≠0, a free-running counter runs 0..AUTO_PERIOD-1 from reset.
  - auto_tick is asserted in the cycle the counter equals AUTO_PERIOD-1.
  - A tick outside STAGED is discarded, not queued.
- Timing: handshake at edge T0 → CEB1 high during cycle T0..T1, B1 valid after T1. Trigger sampled at edge Tc → CEB2 high Tc..Tc+1, B2 valid after Tc+1. commit_done is high in the cycle after edge Tc+1+COMMIT_LAT.
- Simultaneous events:
  - swap_req together with auto_tick counts as a single commit.
  - swap_req in IDLE, LOAD, COMMIT or WAIT is ignored.
  - coef_valid in the same cycle as commit_done is not accepted. coef_ready rises one cycle later.
- Reset mid-operation: any state returns to IDLE with reset values on the next edge. A pending staged coefficient is discarded; CEB1/CEB2 never remain high.
- CEB1 and CEB2 are never high in the same cycle.

Optional Feature:
- Macro: DUAL_B_COEF_CTRL_COMMIT_CNT_EN.
- When defined: adds output commit_cnt [15:0].
  - Reset to 0.
  - Increments by 1 at each commit_done pulse and wraps 16'hFFFF→0.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then coef_valid with coef_data=18'h1F00A → CEB1 high exactly one cycle with B=18'h1F00A; staged=1; coef_ready=0. swap_req at cycle 10 → CEB2 high one cycle at 10..11; commit_done one cycle, 1 cycle later (COMMIT_LAT=1).
- While STAGED, hold coef_valid=1 with data 18'h00055 → not accepted. After commit_done it is accepted 1 cycle later; B=18'h00055.
- AUTO_PERIOD=8, stage a coefficient at cycle 3 → commit triggered at the first counter==7 cycle while STAGED. A tick with nothing staged produces no CEB2.
- Assert rst=0 during COMMIT → the next edge gives CEB2=0, staged=0, state IDLE, B=0, coef_ready=1.
- cfg_cascade=1 toggled during STAGED → B_INPUT stays 1 until IDLE, then 0. cfg_preview=1 → IN_MODE=1 after one edge.
- With DUAL_B_COEF_CTRL_COMMIT_CNT_EN defined, 3 commits → commit_cnt=3. Reset → 0.
